// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state encoding and phase-counter width helper for the reset sequencer
package rst_seq_pkg;
    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        SETTLE  = 3'd1,
        RUN     = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    function automatic int phase_w(input int h, input int s);
        int m;
        m = (h > s) ? h : s;
        m = (m > 2) ? m : 2;
        return $clog2(m);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter with synchronous clear and enable, saturating at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= clr ? '0 : (en && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/rst_seq.sv
// rst_seq: stretches downstream reset, inserts a settle gap, then runs a watchdog-bounded window
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES    = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_rst_req,
    input  logic             done,
    output logic             rst_n_out,
    output logic             run,
    output logic             done_o,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [2:0]       state_o
);
    localparam int PW = phase_w(HOLD_CYCLES, SETTLE_CYCLES);

    state_t        state, nxt;
    logic [PW-1:0] phase;

    always_ff @(posedge clk) begin
        state     <= reset ? HOLD : nxt;
        rst_n_out <= !reset && (nxt inside {SETTLE, RUN, DONE});
        timeout   <= reset ? 1'b0 : timeout | (state == RUN && nxt == TIMEOUT);
    end

    always_comb begin
        nxt = state;
        case (state)
            HOLD:    if (phase == PW'(HOLD_CYCLES - 1)) nxt = (SETTLE_CYCLES == 0) ? RUN : SETTLE;
            SETTLE:  if (phase == PW'(SETTLE_CYCLES - 1)) nxt = RUN;
            RUN:     nxt = done ? DONE
                         : (TIMEOUT_CYCLES != 0 && cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) ? TIMEOUT
                         : RUN;
            default: nxt = state;
        endcase
        if (ext_rst_req) nxt = HOLD;
    end

    // phase restarts on every state change so each phase counts from zero
    sat_counter #(.W(PW)) u_phase (
        .clk (clk),
        .clr (reset || ext_rst_req || nxt != state),
        .en  (state inside {HOLD, SETTLE}),
        .q   (phase)
    );

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk (clk),
        .clr (reset || ext_rst_req),
        .en  (state == RUN && !done),
        .q   (cycle_cnt)
    );

    assign run     = state == RUN;
    assign done_o  = state == DONE;
    assign state_o = state;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed checks of the reset sequencer with default and no-settle/no-watchdog parameters
module tb_rst_seq;
    logic        clk = 0;
    logic        reset = 1, ext_rst_req = 0, done = 0;
    logic        rst_n_out, run, done_o, timeout;
    logic [31:0] cycle_cnt;
    logic [2:0]  state_o;
    logic        reset_b = 1, ext_b = 0, done_b = 0;
    logic        rst_n_b, run_b, done_o_b, timeout_b;
    logic [3:0]  cnt_b;
    logic [2:0]  state_b;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    rst_seq dut (
        .clk(clk), .reset(reset), .ext_rst_req(ext_rst_req), .done(done),
        .rst_n_out(rst_n_out), .run(run), .done_o(done_o), .timeout(timeout),
        .cycle_cnt(cycle_cnt), .state_o(state_o)
    );

    rst_seq #(.SETTLE_CYCLES(0), .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset_b), .ext_rst_req(ext_b), .done(done_b),
        .rst_n_out(rst_n_b), .run(run_b), .done_o(done_o_b), .timeout(timeout_b),
        .cycle_cnt(cnt_b), .state_o(state_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(3);
        check("rst_state", state_o, 0);
        check("rst_rstn", rst_n_out, 0);
        check("rst_run", run, 0);
        check("rst_done_o", done_o, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cnt", cycle_cnt, 0);
        reset = 0;
        tick(3);
        check("hold_e3_rstn", rst_n_out, 0);
        done = 1;
        tick(1);
        done = 0;
        check("hold_e4_rstn", rst_n_out, 1);
        check("hold_e4_state", state_o, 1);
        check("settle_run", run, 0);
        done = 1;
        tick(1);
        done = 0;
        check("settle_done_ignored", state_o, 1);
        tick(1);
        check("e6_run", run, 1);
        check("e6_state", state_o, 2);
        check("e6_cnt", cycle_cnt, 0);
        tick(9);
        check("run10_cnt", cycle_cnt, 9);
        done = 1;
        tick(1);
        done = 0;
        check("done_state", state_o, 3);
        check("done_o", done_o, 1);
        check("done_run", run, 0);
        check("done_cnt", cycle_cnt, 9);
        check("done_rstn", rst_n_out, 1);
        check("done_timeout", timeout, 0);
        tick(3);
        check("done_hold_cnt", cycle_cnt, 9);
        check("done_terminal", state_o, 3);

        ext_rst_req = 1;
        tick(1);
        ext_rst_req = 0;
        check("req_state", state_o, 0);
        check("req_cnt", cycle_cnt, 0);
        check("req_done_o", done_o, 0);
        check("req_rstn", rst_n_out, 0);
        tick(6);
        check("rerun_state", state_o, 2);
        tick(99);
        check("pre_to_cnt", cycle_cnt, 99);
        check("pre_to_state", state_o, 2);
        check("pre_to_flag", timeout, 0);
        tick(1);
        check("to_state", state_o, 4);
        check("to_flag", timeout, 1);
        check("to_rstn", rst_n_out, 0);
        check("to_run", run, 0);
        check("to_cnt", cycle_cnt, 100);
        tick(3);
        check("to_terminal", state_o, 4);
        check("to_cnt_hold", cycle_cnt, 100);

        ext_rst_req = 1;
        tick(1);
        ext_rst_req = 0;
        check("sticky_state", state_o, 0);
        check("sticky_cnt", cycle_cnt, 0);
        check("sticky_flag_hold", timeout, 1);
        tick(6);
        check("sticky_run", run, 1);
        check("sticky_flag_run", timeout, 1);
        reset = 1;
        ext_rst_req = 1;
        tick(1);
        ext_rst_req = 0;
        check("reset_clr_flag", timeout, 0);
        check("reset_state", state_o, 0);
        reset = 0;

        tick(6);
        check("sim_run", state_o, 2);
        tick(99);
        done = 1;
        tick(1);
        done = 0;
        check("sim_state", state_o, 3);
        check("sim_flag", timeout, 0);
        check("sim_cnt", cycle_cnt, 99);

        reset = 1;
        tick(1);
        reset = 0;
        tick(2);
        ext_rst_req = 1;
        tick(1);
        ext_rst_req = 0;
        tick(3);
        check("ext_hold_e3", rst_n_out, 0);
        check("ext_hold_state", state_o, 0);
        tick(1);
        check("ext_hold_e4", rst_n_out, 1);

        reset_b = 0;
        tick(3);
        check("b_e3_rstn", rst_n_b, 0);
        check("b_e3_run", run_b, 0);
        tick(1);
        check("b_e4_rstn", rst_n_b, 1);
        check("b_e4_run", run_b, 1);
        check("b_e4_cnt", cnt_b, 0);
        tick(15);
        check("b_cnt15", cnt_b, 15);
        tick(20);
        check("b_sat", cnt_b, 15);
        check("b_state", state_b, 2);
        check("b_no_to", timeout_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
